// File: rtl/time_fnd_ctrl.sv
// rtl/time_fnd_ctrl.sv - six-digit multiplexed 7-segment driver for an hh:mm:ss watch
//
// Purpose: scans six common-anode digits, converting the binary {hour,min,sec}
// time to decimal digits once per scan frame with a small repeated-subtraction
// converter, and optionally blinks the whole display while paused.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous, active-high
//   i_time     - packed {hour,min,sec} binary time
//   i_pausing  - level, 1 enables display blinking
//   o_fnd_com  - active-low digit enables, com[0] = seconds ones
//   o_fnd_seg  - active-low segments, bit0 = a .. bit6 = g
//   o_fnd_dp   - active-low decimal point (lit after minutes and hours ones)

module time_fnd_ctrl #(
    parameter int SEC_BIT      = 6,
    parameter int MIN_BIT      = 6,
    parameter int HOUR_BIT     = 6,
    parameter int SCAN_CNT_TH  = 100000,
    parameter int BLINK_FRAMES = 50
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [HOUR_BIT+MIN_BIT+SEC_BIT-1:0] i_time,
    input  logic                                i_pausing,
    output logic [5:0]                          o_fnd_com,
    output logic [6:0]                          o_fnd_seg,
    output logic                                o_fnd_dp
);

    localparam int SCAN_W  = $clog2(SCAN_CNT_TH);
    localparam int FRAME_W = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t              state;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [2:0]          digit_idx;
    logic [FRAME_W-1:0]  frame_cnt;
    logic                blink_on;

    logic [SEC_BIT-1:0]  bin_sec;
    logic [MIN_BIT-1:0]  bin_min;
    logic [HOUR_BIT-1:0] bin_hour;
    logic [3:0]          tens_sec;
    logic [3:0]          tens_min;
    logic [3:0]          tens_hour;

    // Digit order matches the scan index: 0 = sec ones .. 5 = hour tens.
    logic [3:0]          res_digit  [6];
    logic [3:0]          disp_digit [6];

    logic scan_tick;
    logic frame_wrap;
    logic sec_ge;
    logic min_ge;
    logic hour_ge;

    assign scan_tick  = (scan_cnt == SCAN_W'(SCAN_CNT_TH - 1));
    assign frame_wrap = scan_tick && (digit_idx == 3'd5);
    assign sec_ge     = (bin_sec  >= SEC_BIT'(10));
    assign min_ge     = (bin_min  >= MIN_BIT'(10));
    assign hour_ge    = (bin_hour >= HOUR_BIT'(10));

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            scan_cnt  <= '0;
            digit_idx <= '0;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
            bin_sec   <= '0;
            bin_min   <= '0;
            bin_hour  <= '0;
            tens_sec  <= '0;
            tens_min  <= '0;
            tens_hour <= '0;
            for (int i = 0; i < 6; i++) begin
                res_digit[i]  <= '0;
                disp_digit[i] <= '0;
            end
            o_fnd_com <= 6'h3F;
            o_fnd_seg <= 7'h7F;
            o_fnd_dp  <= 1'b1;
        end else begin
            // Scan timing
            if (scan_tick) begin
                scan_cnt  <= '0;
                digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end

            // Display registers change only at the frame boundary so a frame
            // never shows digits from two different snapshots.
            if (frame_wrap) begin
                for (int i = 0; i < 6; i++) begin
                    disp_digit[i] <= res_digit[i];
                end
            end

            // Blink phase: free-running only while paused.
            if (!i_pausing) begin
                frame_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (frame_wrap) begin
                if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + FRAME_W'(1);
                end
            end

            // Binary to BCD by parallel repeated subtraction of 10.
            case (state)
                S_IDLE: begin
                    if (frame_wrap) begin
                        {bin_hour, bin_min, bin_sec} <= i_time;
                        tens_sec  <= '0;
                        tens_min  <= '0;
                        tens_hour <= '0;
                        state     <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (sec_ge) begin
                        bin_sec  <= bin_sec - SEC_BIT'(10);
                        tens_sec <= tens_sec + 4'd1;
                    end
                    if (min_ge) begin
                        bin_min  <= bin_min - MIN_BIT'(10);
                        tens_min <= tens_min + 4'd1;
                    end
                    if (hour_ge) begin
                        bin_hour  <= bin_hour - HOUR_BIT'(10);
                        tens_hour <= tens_hour + 4'd1;
                    end
                    if (!sec_ge && !min_ge && !hour_ge) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    res_digit[0] <= 4'(bin_sec);
                    res_digit[1] <= tens_sec;
                    res_digit[2] <= 4'(bin_min);
                    res_digit[3] <= tens_min;
                    res_digit[4] <= 4'(bin_hour);
                    res_digit[5] <= tens_hour;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Outputs show the digit selected by the current index.
            if (i_pausing && !blink_on) begin
                o_fnd_com <= 6'h3F;
                o_fnd_seg <= 7'h7F;
                o_fnd_dp  <= 1'b1;
            end else begin
                o_fnd_com <= ~(6'd1 << digit_idx);
                o_fnd_seg <= seg_code(disp_digit[digit_idx]);
                o_fnd_dp  <= !((digit_idx == 3'd2) || (digit_idx == 3'd4));
            end
        end
    end

endmodule
